// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib kernel job sequencer.
// FIB_SEQ_CYCLE_COUNT_EN adds a per-result cycle count field.
package fib_pkg;

   localparam int N_W        = 6;
   localparam int DATA_W     = 32;
   localparam int TAG_W      = 4;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } seq_state_e;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
`ifdef FIB_SEQ_CYCLE_COUNT_EN
      logic [15:0]       cycles;
`endif
   } res_entry_t;

`ifdef FIB_SEQ_CYCLE_COUNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

endpackage

// File: rtl/fib_result_fifo.sv
// Small synchronous result FIFO; head is read straight from storage so it
// appears on the outputs the cycle after the push.
module fib_result_fifo
   import fib_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     head_valid,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so push-at-full with pop is legal.
   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign head_data  = mem[rd_ptr_reg];
   assign head_valid = (count_reg != '0);
   assign count      = count_reg;

endmodule

// File: rtl/fib_job_sequencer.sv
// Host front end for the fib kernel: launches one job at a time, tags and
// queues the results. FIB_SEQ_CYCLE_COUNT_EN adds the res_cycles output.
module fib_job_sequencer
   import fib_pkg::*;
#(
   parameter int N_W        = fib_pkg::N_W,
   parameter int DATA_W     = fib_pkg::DATA_W,
   parameter int TAG_W      = fib_pkg::TAG_W,
   parameter int FIFO_DEPTH = fib_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [N_W-1:0]    job_n,
   input  logic [DATA_W-1:0] job_a,
   input  logic [DATA_W-1:0] job_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [TAG_W-1:0]  res_tag,
`ifdef FIB_SEQ_CYCLE_COUNT_EN
   output logic [15:0]       res_cycles,
`endif
   output logic              busy,
   output logic              k_r_enable,
   output logic              k_ctrl,
   output logic [N_W-1:0]    k_n,
   output logic [DATA_W-1:0] k_a,
   output logic [DATA_W-1:0] k_b,
   input  logic              k_w_enable,
   input  logic [DATA_W-1:0] k_result
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef FIB_SEQ_CYCLE_COUNT_EN
   localparam int ENTRY_W = TAG_W + DATA_W + 16;
`else
   localparam int ENTRY_W = TAG_W + DATA_W;
`endif

   seq_state_e        state_reg;
   logic              run_reg;
   logic              busy_reg;
   logic              k_r_enable_reg;
   logic [TAG_W-1:0]  tag_reg;
   logic [N_W-1:0]    k_n_reg;
   logic [DATA_W-1:0] k_a_reg;
   logic [DATA_W-1:0] k_b_reg;

   logic [AW:0]        fifo_count;
   logic               fifo_full;
   logic               accept;
   logic               capture;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   // run_reg keeps job_ready low while reset is asserted and for the first edge after.
   assign fifo_full = (fifo_count == (AW+1)'(FIFO_DEPTH));
   assign job_ready = run_reg && (state_reg == IDLE) && !fifo_full;
   assign accept    = job_valid && job_ready;
   assign capture   = (state_reg == WAIT) && k_w_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         run_reg        <= 1'b0;
         busy_reg       <= 1'b0;
         k_r_enable_reg <= 1'b0;
         tag_reg        <= '0;
         k_n_reg        <= '0;
         k_a_reg        <= '0;
         k_b_reg        <= '0;
      end else begin
         run_reg        <= 1'b1;
         k_r_enable_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  k_n_reg        <= job_n;
                  k_a_reg        <= job_a;
                  k_b_reg        <= job_b;
                  k_r_enable_reg <= 1'b1;
                  busy_reg       <= 1'b1;
                  state_reg      <= LAUNCH;
               end
            end
            // w_enable may still be high from the previous job here.
            LAUNCH: state_reg <= WAIT;
            WAIT: begin
               if (k_w_enable) begin
                  tag_reg   <= tag_reg + 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef FIB_SEQ_CYCLE_COUNT_EN
   logic [15:0] cycles_reg;

   // Counts LAUNCH/WAIT cycles seen so far; the capture cycle is added at push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycles_reg <= '0;
      end else if (accept) begin
         cycles_reg <= '0;
      end else if (state_reg != IDLE) begin
         cycles_reg <= sat_inc16(cycles_reg);
      end
   end

   assign push_entry = {tag_reg, k_result, sat_inc16(cycles_reg)};
   assign res_cycles = head_entry[15:0];
   assign res_data   = head_entry[16 +: DATA_W];
`else
   assign push_entry = {tag_reg, k_result};
   assign res_data   = head_entry[0 +: DATA_W];
`endif
   assign res_tag    = head_entry[ENTRY_W-1 -: TAG_W];

   fib_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (capture),
      .push_data  (push_entry),
      .pop        (res_ready),
      .head_data  (head_entry),
      .head_valid (res_valid),
      .count      (fifo_count)
   );

   assign busy       = busy_reg;
   assign k_r_enable = k_r_enable_reg;
   assign k_ctrl     = 1'b0;
   assign k_n        = k_n_reg;
   assign k_a        = k_a_reg;
   assign k_b        = k_b_reg;

endmodule
